// File: rtl/encoder_tx_fsm_if.sv
// encoder_tx_fsm_if: block stream bus between the upstream 64b/66b encoder (master) and encoder_tx_fsm (slave)
interface encoder_tx_fsm_if #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int LEN_ERR_CNT = 16
);
  logic                       i_enable;
  logic [3:0]                 i_t_type;
  logic [LEN_CODED_BLOCK-1:0] i_tx_coded;
  logic [LEN_CODED_BLOCK-1:0] o_tx_coded;
  logic                       o_valid;
  logic [2:0]                 o_state;
  logic [LEN_ERR_CNT-1:0]     o_err_count;
  modport master (
    output i_enable, i_t_type, i_tx_coded,
    input  o_tx_coded, o_valid, o_state, o_err_count
  );
  modport slave (
    input  i_enable, i_t_type, i_tx_coded,
    output o_tx_coded, o_valid, o_state, o_err_count
  );
endinterface

// File: rtl/encoder_tx_fsm.sv
// encoder_tx_fsm: 10GBASE-R transmit state machine; i_clock/i_reset (sync, active-high) plus slave bus carrying enable, block type and 66b block in, registered block/valid/state/error count out
module encoder_tx_fsm #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int LEN_ERR_CNT = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  encoder_tx_fsm_if.slave    bus
);
  typedef enum logic [2:0] {
    TX_INIT = 3'd0,
    TX_C    = 3'd1,
    TX_D    = 3'd2,
    TX_T    = 3'd3,
    TX_E    = 3'd4
  } state_e;
  localparam logic [LEN_CODED_BLOCK-1:0] EBLOCK_T = LEN_CODED_BLOCK'(66'h2_1E3C_78F1_E3C7_8F1E);
  localparam logic [LEN_CODED_BLOCK-1:0] LBLOCK_T = LEN_CODED_BLOCK'({2'b10, 8'h4B, 24'h000001, 4'h0, 28'h0});
  state_e                     state_q, state_d;
  logic [LEN_CODED_BLOCK-1:0] tx_q;
  logic                       valid_q;
  logic [LEN_ERR_CNT-1:0]     err_q;
  logic                       is_d, is_s, is_c, is_t;
  assign is_d = bus.i_t_type == 4'b1000;
  assign is_s = bus.i_t_type == 4'b0100;
  assign is_c = bus.i_t_type == 4'b0010;
  assign is_t = bus.i_t_type == 4'b0001;
  always_comb begin
    state_d = TX_E;
    case (state_q)
      TX_D:    state_d = is_d ? TX_D : is_t ? TX_T : TX_E;
      TX_E:    state_d = is_d ? TX_D : is_c ? TX_C : is_t ? TX_T : TX_E;
      default: state_d = is_c ? TX_C : is_s ? TX_D : TX_E;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= TX_INIT;
      tx_q    <= LBLOCK_T;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      valid_q <= bus.i_enable;
      if (bus.i_enable) begin
        state_q <= state_d;
        tx_q    <= (state_d == TX_E) ? EBLOCK_T : bus.i_tx_coded;
        if (state_d == TX_E && err_q != '1) err_q <= err_q + 1'b1;
      end
    end
  end
  assign bus.o_state     = state_q;
  assign bus.o_tx_coded  = tx_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_err_count = err_q;
endmodule
